// File: rtl/bus_arbiter_if.sv
// Request/response link shared by the CPU, the DMA engine and the slave decode:
// valid/addr/wdata/wstrb travel towards the slave, ready/rdata travel back.
interface bus_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between the CPU and a DMA engine.
// Each grant is held until the slave responds, the owner aborts, or the watchdog fires.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'h0
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_arbiter_if.slave  cpu,
    bus_arbiter_if.slave  dma,
    bus_arbiter_if.master bus,
    output logic          bus_owner,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        owner, owner_next;
    logic        last_grant, last_grant_next;
    logic [15:0] wd_cnt, wd_cnt_next;
    logic [31:0] resp_rdata, resp_rdata_next;
    logic        grant;
    logic        wd_hit;

    logic        own_valid;
    logic [31:0] own_addr;
    logic [31:0] own_wdata;
    logic [3:0]  own_wstrb;

    assign own_valid = owner ? dma.valid : cpu.valid;
    assign own_addr  = owner ? dma.addr  : cpu.addr;
    assign own_wdata = owner ? dma.wdata : cpu.wdata;
    assign own_wstrb = owner ? dma.wstrb : cpu.wstrb;

    assign wd_hit = WD_EN && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wd_cnt     <= 16'h0;
            resp_rdata <= 32'h0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
            wd_cnt     <= wd_cnt_next;
            resp_rdata <= resp_rdata_next;
        end
    end

    // A slave response in the watchdog's final cycle wins over the timeout.
    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        wd_cnt_next     = wd_cnt;
        resp_rdata_next = resp_rdata;
        grant           = 1'b0;
        timeout_err     = 1'b0;

        case (state)
            IDLE: begin
                if (cpu.valid || dma.valid) begin
                    grant           = (cpu.valid && dma.valid) ? !last_grant : dma.valid;
                    owner_next      = grant;
                    last_grant_next = grant;
                    wd_cnt_next     = 16'h0;
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                if (!own_valid) begin
                    state_next = IDLE;
                end else if (bus.ready) begin
                    resp_rdata_next = bus.rdata;
                    state_next      = RESP;
                end else if (wd_hit) begin
                    resp_rdata_next = ERR_RDATA;
                    timeout_err     = 1'b1;
                    state_next      = RESP;
                end else if (WD_EN) begin
                    wd_cnt_next = wd_cnt + 16'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Master responses come only from registered state, never straight from bus.ready.
    always_comb begin
        bus.valid = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.wstrb = 4'h0;
        cpu.ready = 1'b0;
        cpu.rdata = 32'h0;
        dma.ready = 1'b0;
        dma.rdata = 32'h0;
        bus_owner = 1'b0;

        case (state)
            BUSY: begin
                bus.valid = own_valid;
                bus.addr  = own_addr;
                bus.wdata = own_wdata;
                bus.wstrb = own_valid ? own_wstrb : 4'h0;
                bus_owner = owner;
            end
            RESP: begin
                bus_owner = owner;
                if (owner) begin
                    dma.ready = 1'b1;
                    dma.rdata = resp_rdata;
                end else begin
                    cpu.ready = 1'b1;
                    cpu.rdata = resp_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
